// File: rtl/inst_buffer.sv
// rtl/inst_buffer.sv - dual-push/dual-pop instruction queue between fetch and decode
// Optional zero-latency fetch-to-decode bypass when empty: define INST_BUFFER_BYPASS_EN.
module inst_buffer #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic [1:0]               in_valid,
    input  logic [1:0][31:0]         in_pc,
    input  logic [1:0][31:0]         in_inst,
    input  logic [1:0]               in_exc,
    input  logic [1:0][6:0]          in_exc_cause,
    output logic                     in_ready,
    output logic [1:0]               out_valid,
    output logic [1:0][31:0]         out_pc,
    output logic [1:0][31:0]         out_inst,
    output logic [1:0]               out_exc,
    output logic [1:0][6:0]          out_exc_cause,
    input  logic [1:0]               out_pop,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0] pc_mem    [DEPTH];
    logic [31:0] inst_mem  [DEPTH];
    logic        exc_mem   [DEPTH];
    logic [6:0]  cause_mem [DEPTH];

    logic [AW-1:0] head, tail, head_p1, tail_p1;
    logic [CW-1:0] count_q;
    logic          push0, push1, pop0, pop1, bypass;
    logic [1:0]    npush, npop, skip, hpop;
    logic          wa_en, wa_sel1, wb_en;

    assign head_p1  = head + AW'(1);
    assign tail_p1  = tail + AW'(1);
    assign count    = count_q;
    assign in_ready = (count_q <= CW'(DEPTH - 2));

    // Slot 1 is only meaningful together with slot 0.
    assign push0 = in_ready & in_valid[0];
    assign push1 = in_ready & in_valid[0] & in_valid[1];

`ifdef INST_BUFFER_BYPASS_EN
    assign bypass = (count_q == '0) & ~flush & in_ready;
`else
    assign bypass = 1'b0;
`endif

    always_comb begin
        out_valid        = {count_q >= CW'(2), count_q != '0};
        out_pc[0]        = pc_mem[head];
        out_pc[1]        = pc_mem[head_p1];
        out_inst[0]      = inst_mem[head];
        out_inst[1]      = inst_mem[head_p1];
        out_exc[0]       = exc_mem[head];
        out_exc[1]       = exc_mem[head_p1];
        out_exc_cause[0] = cause_mem[head];
        out_exc_cause[1] = cause_mem[head_p1];
        if (bypass) begin
            out_valid     = {push1, push0};
            out_pc        = in_pc;
            out_inst      = in_inst;
            out_exc       = in_exc;
            out_exc_cause = in_exc_cause;
        end
    end

    assign pop0  = out_pop[0] & out_valid[0];
    assign pop1  = out_pop[1] & out_pop[0] & out_valid[1];
    assign npush = {1'b0, push0} + {1'b0, push1};
    assign npop  = {1'b0, pop0} + {1'b0, pop1};

    // In bypass, popped entries come straight from the push slots and are never stored.
    assign skip  = bypass ? npop : 2'd0;
    assign hpop  = bypass ? 2'd0 : npop;

    assign wa_en   = ((skip == 2'd0) & push0) | ((skip == 2'd1) & push1);
    assign wa_sel1 = (skip == 2'd1);
    assign wb_en   = (skip == 2'd0) & push1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
        end else if (flush) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
        end else begin
            head    <= head + AW'(hpop);
            tail    <= tail + AW'(npush - skip);
            count_q <= count_q + CW'(npush) - CW'(npop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem[i]    <= '0;
                inst_mem[i]  <= '0;
                exc_mem[i]   <= 1'b0;
                cause_mem[i] <= '0;
            end
        end else if (!flush) begin
            if (wa_en) begin
                pc_mem[tail]    <= wa_sel1 ? in_pc[1]        : in_pc[0];
                inst_mem[tail]  <= wa_sel1 ? in_inst[1]      : in_inst[0];
                exc_mem[tail]   <= wa_sel1 ? in_exc[1]       : in_exc[0];
                cause_mem[tail] <= wa_sel1 ? in_exc_cause[1] : in_exc_cause[0];
            end
            if (wb_en) begin
                pc_mem[tail_p1]    <= in_pc[1];
                inst_mem[tail_p1]  <= in_inst[1];
                exc_mem[tail_p1]   <= in_exc[1];
                cause_mem[tail_p1] <= in_exc_cause[1];
            end
        end
    end
endmodule

// File: tb/tb_inst_buffer.sv
// tb/tb_inst_buffer.sv - randomized self-checking bench for inst_buffer against a queue model
module tb_inst_buffer;
    localparam int DEPTH = 8;
`ifdef INST_BUFFER_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        exc;
        logic [6:0]  cause;
    } ent_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             flush = 1'b0;
    logic [1:0]       in_valid = '0;
    logic [1:0][31:0] in_pc = '0;
    logic [1:0][31:0] in_inst = '0;
    logic [1:0]       in_exc = '0;
    logic [1:0][6:0]  in_exc_cause = '0;
    logic             in_ready;
    logic [1:0]       out_valid;
    logic [1:0][31:0] out_pc;
    logic [1:0][31:0] out_inst;
    logic [1:0]       out_exc;
    logic [1:0][6:0]  out_exc_cause;
    logic [1:0]       out_pop = '0;
    logic [3:0]       count;

    inst_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_pc(in_pc), .in_inst(in_inst),
        .in_exc(in_exc), .in_exc_cause(in_exc_cause), .in_ready(in_ready),
        .out_valid(out_valid), .out_pc(out_pc), .out_inst(out_inst),
        .out_exc(out_exc), .out_exc_cause(out_exc_cause),
        .out_pop(out_pop), .count(count)
    );

    always #5 clk = ~clk;

    ent_t got_e0, got_e1;
    assign got_e0 = {out_pc[0], out_inst[0], out_exc[0], out_exc_cause[0]};
    assign got_e1 = {out_pc[1], out_inst[1], out_exc[1], out_exc_cause[1]};

    ent_t        q[$];
    ent_t        pl[$];
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] nxt_pc = 32'h1c00_0000;
    ent_t        exp_e0, exp_e1;
    logic [1:0]  exp_valid;
    int          exp_count;
    logic        exp_ready;

    task automatic drive(input logic [1:0] v, input logic [1:0] pop, input logic fl);
        in_valid        = v;
        out_pop         = pop;
        flush           = fl;
        in_pc[0]        = nxt_pc;
        in_pc[1]        = nxt_pc + 32'd4;
        in_inst[0]      = $urandom;
        in_inst[1]      = $urandom;
        in_exc          = '0;
        in_exc_cause    = '0;
    endtask

    // Expected pre-edge view: occupancy, readiness and the two presented entries.
    task automatic settle();
        ent_t pres[$];
        #1;
        pl = {};
        if (in_valid[0]) pl.push_back({in_pc[0], in_inst[0], in_exc[0], in_exc_cause[0]});
        if (in_valid[0] && in_valid[1]) pl.push_back({in_pc[1], in_inst[1], in_exc[1], in_exc_cause[1]});
        exp_count = q.size();
        exp_ready = (DEPTH - q.size()) >= 2;
        pres = (BYP && q.size() == 0 && !flush) ? pl : q;
        exp_valid = {pres.size() >= 2, pres.size() >= 1};
        exp_e0 = (pres.size() >= 1) ? pres[0] : '0;
        exp_e1 = (pres.size() >= 2) ? pres[1] : '0;
    endtask

    task automatic tick();
        int npop;
        npop = int'(out_pop[0] & exp_valid[0]) + int'(out_pop[1] & out_pop[0] & exp_valid[1]);
        @(posedge clk);
        if (exp_ready || flush) nxt_pc = nxt_pc + 32'(4 * pl.size());
        if (flush) q = {};
        else begin
            if (exp_ready) foreach (pl[i]) q.push_back(pl[i]);
            repeat (npop) void'(q.pop_front());
        end
        @(negedge clk);
        drive(2'b00, 2'b00, 1'b0);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        #1;
        n_vec++; if (out_valid !== 2'b00) begin n_err++; $display("FAIL reset_valid got %b want 00", out_valid); end
        n_vec++; if (count !== 4'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", count); end
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b want 1", in_ready); end
        n_vec++; if (out_pc !== 64'd0) begin n_err++; $display("FAIL reset_pc got %h want 0", out_pc); end
        @(negedge clk);
        rst_n = 1'b1;
        q = {};
    endtask

    task automatic test_push_basic();
        nxt_pc = 32'h1c00_0000;
        drive(2'b11, 2'b00, 1'b0);
        settle();
        if (BYP) begin
            n_vec++; if (out_valid !== 2'b11) begin n_err++; $display("FAIL bypass_valid got %b want 11", out_valid); end
        end
        tick();
        settle();
        n_vec++; if (out_valid !== 2'b11) begin n_err++; $display("FAIL basic_valid got %b want 11", out_valid); end
        n_vec++; if (out_pc[0] !== 32'h1c00_0000 || out_pc[1] !== 32'h1c00_0004)
            begin n_err++; $display("FAIL basic_pc got %h %h want 1c000000 1c000004", out_pc[0], out_pc[1]); end
        n_vec++; if (count !== 4'd2) begin n_err++; $display("FAIL basic_count got %0d want 2", count); end
        n_vec++; if (got_e0 !== exp_e0 || got_e1 !== exp_e1) begin n_err++; $display("FAIL basic_entry got %h want %h", got_e0, exp_e0); end
        drive(2'b00, 2'b11, 1'b0); settle(); tick();
    endtask

    task automatic test_fill();
        for (int i = 0; i < 5; i++) begin
            drive(2'b11, 2'b00, 1'b0);
            settle();
            n_vec++; if (in_ready !== exp_ready) begin n_err++; $display("FAIL fill_ready[%0d] got %b want %b", i, in_ready, exp_ready); end
            n_vec++; if (count !== 4'(exp_count)) begin n_err++; $display("FAIL fill_count[%0d] got %0d want %0d", i, count, exp_count); end
            tick();
        end
        settle();
        n_vec++; if (count !== 4'd8 || in_ready !== 1'b0) begin n_err++; $display("FAIL full got count %0d ready %b want 8 0", count, in_ready); end
        drive(2'b00, 2'b01, 1'b0); settle(); tick();
        drive(2'b11, 2'b00, 1'b0); settle();
        n_vec++; if (count !== 4'd7 || in_ready !== 1'b0) begin n_err++; $display("FAIL seven got count %0d ready %b want 7 0", count, in_ready); end
        tick();
        settle();
        n_vec++; if (count !== 4'd7 || got_e0 !== exp_e0) begin n_err++; $display("FAIL seven_hold got count %0d pc %h want 7 %h", count, out_pc[0], exp_e0.pc); end
        drive(2'b00, 2'b00, 1'b1); settle(); tick();
    endtask

    task automatic test_wrap();
        logic [31:0] prev;
        drive(2'b11, 2'b00, 1'b0); settle(); tick();
        drive(2'b11, 2'b00, 1'b0); settle(); tick();
        prev = out_pc[0] - 32'd8;
        for (int i = 0; i < 20; i++) begin
            drive(2'b11, 2'b11, 1'b0);
            settle();
            n_vec++; if (out_pc[0] !== prev + 32'd8 || out_pc[1] !== prev + 32'd12 || got_e0 !== exp_e0)
                begin n_err++; $display("FAIL wrap_seq[%0d] got %h %h want %h", i, out_pc[0], out_pc[1], prev + 32'd8); end
            n_vec++; if (count !== 4'd4) begin n_err++; $display("FAIL wrap_count[%0d] got %0d want 4", i, count); end
            prev = out_pc[0];
            tick();
        end
        drive(2'b00, 2'b00, 1'b1); settle(); tick();
    endtask

    task automatic test_push1_pop2();
        logic [31:0] newpc;
        drive(2'b11, 2'b00, 1'b0); settle(); tick();
        drive(2'b01, 2'b11, 1'b0);
        newpc = in_pc[0];
        settle(); tick();
        settle();
        n_vec++; if (count !== 4'd1) begin n_err++; $display("FAIL p1p2_count got %0d want 1", count); end
        n_vec++; if (out_pc[0] !== newpc || out_valid !== 2'b01) begin n_err++; $display("FAIL p1p2_pc got %h/%b want %h/01", out_pc[0], out_valid, newpc); end
        drive(2'b00, 2'b00, 1'b1); settle(); tick();
    endtask

    task automatic test_flush();
        logic [31:0] lost;
        drive(2'b11, 2'b00, 1'b0); settle(); tick();
        drive(2'b11, 2'b00, 1'b0); settle(); tick();
        drive(2'b01, 2'b00, 1'b0); settle(); tick();
        settle();
        n_vec++; if (count !== 4'd5) begin n_err++; $display("FAIL flush_pre got %0d want 5", count); end
        drive(2'b11, 2'b11, 1'b1);
        lost = in_pc[0];
        settle(); tick();
        settle();
        n_vec++; if (count !== 4'd0 || out_valid !== 2'b00) begin n_err++; $display("FAIL flush_clear got count %0d valid %b want 0 00", count, out_valid); end
        drive(2'b01, 2'b00, 1'b0); settle(); tick();
        settle();
        n_vec++; if (out_pc[0] === lost || got_e0 !== exp_e0 || count !== 4'd1)
            begin n_err++; $display("FAIL flush_stale got %h count %0d want %h 1", out_pc[0], count, exp_e0.pc); end
        drive(2'b00, 2'b00, 1'b1); settle(); tick();
    endtask

    task automatic test_exc();
        drive(2'b11, 2'b00, 1'b0);
        in_exc = 2'b01;
        in_exc_cause[0] = 7'h08;
        settle(); tick();
        settle();
        n_vec++; if (out_exc !== 2'b01 || out_exc_cause[0] !== 7'h08)
            begin n_err++; $display("FAIL exc_tag got %b %h want 01 08", out_exc, out_exc_cause[0]); end
        n_vec++; if (got_e0 !== exp_e0 || got_e1 !== exp_e1) begin n_err++; $display("FAIL exc_entry got %h want %h", got_e0, exp_e0); end
    endtask

    task automatic test_random();
        logic [1:0] v, p;
        for (int i = 0; i < 400; i++) begin
            v = ($urandom_range(0, 2) == 0) ? 2'b00 : (($urandom_range(0, 1) == 0) ? 2'b01 : 2'b11);
            p = ($urandom_range(0, 2) == 0) ? 2'b00 : (($urandom_range(0, 1) == 0) ? 2'b01 : 2'b11);
            drive(v, p, $urandom_range(0, 31) == 0);
            settle();
            n_vec++;
            if (out_valid !== exp_valid || count !== 4'(exp_count) || in_ready !== exp_ready ||
                (exp_valid[0] && got_e0 !== exp_e0) || (exp_valid[1] && got_e1 !== exp_e1))
            begin
                n_err++;
                $display("FAIL random[%0d] got v%b c%0d r%b pc%h want v%b c%0d r%b pc%h",
                         i, out_valid, count, in_ready, out_pc[0], exp_valid, exp_count, exp_ready, exp_e0.pc);
            end
            tick();
        end
    endtask

    task automatic test_async_reset();
        drive(2'b11, 2'b00, 1'b0); settle(); tick();
        drive(2'b11, 2'b00, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++; if (out_valid !== 2'b00 || count !== 4'd0 || in_ready !== 1'b1)
            begin n_err++; $display("FAIL async_reset got v%b c%0d r%b want 00 0 1", out_valid, count, in_ready); end
        n_vec++; if (got_e0 !== '0) begin n_err++; $display("FAIL async_data got %h want 0", got_e0); end
        drive(2'b00, 2'b00, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        q = {};
        settle();
        n_vec++; if (out_valid !== 2'b00 || count !== 4'd0) begin n_err++; $display("FAIL post_reset got v%b c%0d want 00 0", out_valid, count); end
    endtask

    initial begin
        test_reset();
        test_push_basic();
        test_fill();
        test_wrap();
        test_push1_pop2();
        test_flush();
        test_exc();
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/inst_buffer.md
# inst_buffer

Instruction buffer between the fetch stage and the dual decoders. Accepts up to two fetched instructions per cycle (pc, instruction word, fetch exception tag). Holds them in a circular queue and presents the two oldest to the decode slots every cycle. Decouples fetch stalls from decode/issue back-pressure and discards all contents on a pipeline flush.

## Interface
- DEPTH, 8, number of entries; power of two, minimum 4
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- flush  in  1  discard all entries (branch mispredict / exception redirect)
- in_valid  in  [1:0]  push slot valid; in_valid[1] only legal with in_valid[0]
- in_pc  in  [1:0][31:0]  pc per push slot
- in_inst  in  [1:0][31:0]  instruction word per push slot
- in_exc  in  [1:0]  fetch exception flag per slot (ADEF, TLB refill, ...)
- in_exc_cause  in  [1:0][6:0]  exception code per slot, same encoding as decode exception_cause
- in_ready  out  1  buffer can accept two entries this cycle
- out_valid  out  [1:0]  decode slot holds a valid entry; out_valid[1] implies out_valid[0]
- out_pc, out_inst  out  [1:0][31:0]  oldest (slot 0) and second-oldest (slot 1) entry
- out_exc  out  [1:0]; out_exc_cause  out  [1:0][6:0]  tags of the presented entries
- out_pop  in  [1:0]  decode consumed slot; out_pop[1] only with out_pop[0]
- count  out  $clog2(DEPTH)+1  current occupancy

## Operation
- Storage: DEPTH entries of {pc, inst, exc, exc_cause}; head/tail pointers of $clog2(DEPTH) bits, wrap modulo DEPTH; separate occupancy counter.
- Push: when in_ready=1, entries with in_valid set are written at tail, tail+1 (slot 0 first). npush = popcount(in_valid). When in_ready=0, inputs are ignored; fetch holds them.
- in_ready = (DEPTH - count >= 2), from registered count only; same-cycle pops do not raise it.
- Pop: effective pop[i] = out_pop[i] & out_valid[i]. Pops not backed by valid entries are ignored. out_pop[1] without out_pop[0] is illegal and treated as no pop.
- Occupancy next = count + npush - npop, all in the same cycle. Push and pop may coincide at any occupancy, including full-minus-two and empty+push.
- Output read: out_* are a combinational read of entries at head and head+1 (wrapping). out_valid[0] = count>=1, out_valid[1] = count>=2. The out_pc/out_inst of an invalid slot are don't-care but must not be X after reset.
- Flush: highest priority. Next cycle head=tail=count=0. Same-cycle push and pop are discarded. out_valid=0 from the cycle after flush.
- Reset (rst_n low, any time, including mid-push): head=tail=count=0, out_valid=0, in_ready=1, all storage and out_* data cleared to 0.

## Timing
- Push-to-present latency: 1 cycle. An entry written at edge N is visible on out_* after edge N.
- Pop effect: head advances at the edge ending the pop cycle. The new oldest entry is presented the following cycle.
- No combinational path from out_pop to in_ready. Only the bypass configuration has a path from in_* to out_*.
- Full: count=DEPTH-1 or DEPTH → in_ready=0. count never exceeds DEPTH.

## Configuration
- INST_BUFFER_BYPASS_EN defined:
  - When count=0, flush=0 and in_ready=1, out_valid/out_* mirror in_valid/in_* in the same cycle (zero-latency fetch-to-decode).
  - Entries popped that cycle are not written. Remaining entries are written at tail.
  - Example: two pushed, one popped → one stored.
- Undefined: no bypass; out_* driven only from storage, 1-cycle minimum latency.

## Test plan
- Reset then push {pc 0x1c000000, 0x1c000004} with in_valid=2'b11 and no pop → next cycle out_valid=2'b11, out_pc matches, count=2. With bypass: visible in the push cycle, count=0 if both popped.
- Fill DEPTH=8: push 2 per cycle for 4 cycles, no pops → count=8, in_ready=0 from count=7. A fifth push is ignored and count stays 8.
- Wrap: steady push 2 / pop 2 for 20 cycles → pc sequence strictly increasing by 4, no gaps or duplicates across the pointer wrap, count constant.
- Simultaneous push 1 / pop 2 at count=2 → count=1 next cycle, out_pc[0] equals the newly pushed pc.
- Flush with push 2'b11 and pop 2'b11 at count=5 → count=0, out_valid=0 next cycle. The pushed entries never appear.
- Exception tag: push in_exc=2'b01, in_exc_cause[0]=ADEF → out_exc[0]=1, out_exc_cause[0]=ADEF, out_exc[1]=0. rst_n asserted mid-stream clears out_valid immediately (asynchronously).
